// File: rtl/hidden_spike_aer_sequencer_pkg.sv
// Shared constants and state encoding for the hidden-layer AER sequencer.
package hidden_spike_aer_sequencer_pkg;

    localparam int DEF_AER_W = 6;
    localparam int CLASS_W   = 5;
    localparam int FEV_W     = 12;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_SCAN       = 3'd1;
    localparam state_t S_ISSUE      = 3'd2;
    localparam state_t S_WAIT_DONE  = 3'd3;
    localparam state_t S_STEP_END   = 3'd4;
    localparam state_t S_WIN        = 3'd5;
    localparam state_t S_WAIT_INFER = 3'd6;
    localparam state_t S_REPORT     = 3'd7;

endpackage

// File: rtl/hidden_spike_aer_sequencer_if.sv
// Vector intake, AER event and winner handshake bundle between the hidden layer, sequencer and accumulator.
interface hidden_spike_aer_sequencer_if
    import hidden_spike_aer_sequencer_pkg::*;
#(
    parameter int NUM_HIDDEN = 64,
    parameter int AER_W      = DEF_AER_W
);
    logic                  vec_valid;
    logic [NUM_HIDDEN-1:0] vec_data;
    logic                  vec_ready;
    logic                  spike_in;
    logic [AER_W-1:0]      spike_AER;
    logic                  spike_done;
    logic                  get_winner;
    logic                  infer_ready;
    logic [CLASS_W-1:0]    winner_id;
    logic                  class_valid;
    logic [CLASS_W-1:0]    class_id;
    logic [FEV_W-1:0]      frame_events;

    modport master (
        output vec_valid, vec_data, spike_done, infer_ready, winner_id,
        input  vec_ready, spike_in, spike_AER, get_winner, class_valid, class_id, frame_events
    );

    modport slave (
        input  vec_valid, vec_data, spike_done, infer_ready, winner_id,
        output vec_ready, spike_in, spike_AER, get_winner, class_valid, class_id, frame_events
    );
endinterface

// File: rtl/hidden_spike_aer_sequencer_lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_bit_enc #(
    parameter int N = 64,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
        any = |vec;
    end
endmodule

// File: rtl/hidden_spike_aer_sequencer.sv
// Serialises one hidden spike vector per timestep into AER events and fetches the frame winner.
//   state      | meaning
//   IDLE       | ready for the next timestep vector
//   SCAN       | pick lowest pending neuron, or finish the step
//   ISSUE      | one-cycle spike_in pulse
//   WAIT_DONE  | hold address until accumulator spike_done
//   STEP_END   | advance timestep, or end frame
//   WIN        | one-cycle get_winner pulse
//   WAIT_INFER | wait for infer_ready, latch winner_id
//   REPORT     | schedule class_valid
module hidden_spike_aer_sequencer
    import hidden_spike_aer_sequencer_pkg::*;
#(
    parameter int NUM_HIDDEN = 64,
    parameter int AER_W      = DEF_AER_W,
    parameter int NUM_STEPS  = 8
) (
    input logic clk,
    input logic rst_n,
    hidden_spike_aer_sequencer_if.slave bus
);
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t                state, state_nxt;
    logic [NUM_HIDDEN-1:0] pending;
    logic [STEP_W-1:0]     step_cnt;
    logic [AER_W-1:0]      enc_idx;
    logic                  enc_any;
    logic [AER_W-1:0]      spike_aer_q;
    logic [FEV_W-1:0]      frame_events_q;
    logic [CLASS_W-1:0]    class_id_q;
    logic                  class_valid_q;

    lowest_set_bit_enc #(.N(NUM_HIDDEN), .W(AER_W)) u_enc (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (bus.vec_valid) state_nxt = S_SCAN;
            S_SCAN:       state_nxt = enc_any ? S_ISSUE : S_STEP_END;
            S_ISSUE:      state_nxt = S_WAIT_DONE;
            S_WAIT_DONE:  if (bus.spike_done) state_nxt = S_SCAN;
            S_STEP_END:   state_nxt = (step_cnt == LAST_STEP) ? S_WIN : S_IDLE;
            S_WIN:        state_nxt = S_WAIT_INFER;
            S_WAIT_INFER: if (bus.infer_ready) state_nxt = S_REPORT;
            S_REPORT:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pending        <= '0;
            step_cnt       <= '0;
            spike_aer_q    <= '0;
            frame_events_q <= '0;
            class_id_q     <= '0;
            class_valid_q  <= 1'b0;
        end else begin
            state         <= state_nxt;
            // registered so class_valid lands two cycles after infer_ready
            class_valid_q <= (state == S_REPORT);
            case (state)
                S_IDLE: begin
                    if (bus.vec_valid) begin
                        pending <= bus.vec_data;
                        if (step_cnt == '0) frame_events_q <= '0;
                    end
                end
                S_SCAN: begin
                    if (enc_any) begin
                        spike_aer_q <= enc_idx;
                        pending     <= pending & (pending - NUM_HIDDEN'(1));
                    end
                end
                S_ISSUE: begin
                    if (frame_events_q != '1) frame_events_q <= frame_events_q + FEV_W'(1);
                end
                S_STEP_END: begin
                    step_cnt <= (step_cnt == LAST_STEP) ? '0 : step_cnt + STEP_W'(1);
                end
                S_WAIT_INFER: begin
                    if (bus.infer_ready) class_id_q <= bus.winner_id;
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_ready    = (state == S_IDLE);
    assign bus.spike_in     = (state == S_ISSUE);
    assign bus.get_winner   = (state == S_WIN);
    assign bus.spike_AER    = spike_aer_q;
    assign bus.class_valid  = class_valid_q;
    assign bus.class_id     = class_id_q;
    assign bus.frame_events = frame_events_q;

endmodule

// File: tb/tb_hidden_spike_aer_sequencer.sv
// Scripted-timeline bench: the stimulus knows when each output must move and a
// negedge process compares every output against those expectations each cycle.
module tb_hidden_spike_aer_sequencer;
    localparam int NH = 64;
    localparam int AW = 6;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hidden_spike_aer_sequencer_if #(.NUM_HIDDEN(NH), .AER_W(AW)) bus ();

    hidden_spike_aer_sequencer #(.NUM_HIDDEN(NH), .AER_W(AW), .NUM_STEPS(NS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // expected outputs for the current cycle
    logic          e_ready, e_spike, e_getw, e_cvalid;
    logic [AW-1:0] e_aer;
    logic [4:0]    e_cid;
    logic [11:0]   e_fev;
    int            m_step;
    bit            chk_en = 1'b0;
    int            vectors = 0;
    int            miscompares = 0;
    logic [NH-1:0] fv [NS];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("vec_ready",    64'(bus.vec_ready),    64'(e_ready));
            cmp("spike_in",     64'(bus.spike_in),     64'(e_spike));
            cmp("spike_AER",    64'(bus.spike_AER),    64'(e_aer));
            cmp("get_winner",   64'(bus.get_winner),   64'(e_getw));
            cmp("class_valid",  64'(bus.class_valid),  64'(e_cvalid));
            cmp("class_id",     64'(bus.class_id),     64'(e_cid));
            cmp("frame_events", 64'(bus.frame_events), 64'(e_fev));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit r, input bit s, input bit g, input bit v);
        e_ready = r; e_spike = s; e_getw = g; e_cvalid = v;
    endtask

    task automatic reset_model();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        e_aer = '0; e_cid = '0; e_fev = '0; m_step = 0;
    endtask

    // Starts in an IDLE cycle, ends in the first plain IDLE cycle after the step.
    task automatic do_step(input logic [NH-1:0] vec, input int abort_evt, input bit ir_early,
                           input logic [4:0] win, output bit aborted);
        int n = 0;
        aborted = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        bus.vec_valid  = 1'b1;
        bus.vec_data   = vec;
        bus.spike_done = ($urandom_range(0, 1) == 1);
        tick();                                          // SCAN
        bus.vec_valid  = 1'b0;
        bus.vec_data   = {$urandom, $urandom};
        bus.spike_done = 1'b0;
        if (m_step == 0) e_fev = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NH; i++) begin
            if (vec[i]) begin
                tick();                                  // ISSUE
                e_aer = AW'(i);
                set_exp(1'b0, 1'b1, 1'b0, 1'b0);
                bus.spike_done = ($urandom_range(0, 3) == 0);
                tick();                                  // WAIT_DONE
                set_exp(1'b0, 1'b0, 1'b0, 1'b0);
                if (e_fev != 12'hFFF) e_fev = e_fev + 12'd1;
                bus.spike_done = 1'b0;
                if (n == abort_evt) begin
                    rst_n = 1'b0;
                    reset_model();
                    tick();
                    rst_n = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                repeat ($urandom_range(0, 3)) tick();
                bus.spike_done = 1'b1;
                tick();                                  // SCAN
                bus.spike_done = 1'b0;
                n++;
            end
        end
        tick();                                          // STEP_END
        bus.winner_id = ~win;
        if (m_step == NS - 1) begin
            m_step = 0;
            tick();                                      // WIN
            set_exp(1'b0, 1'b0, 1'b1, 1'b0);
            tick();                                      // WAIT_INFER
            set_exp(1'b0, 1'b0, 1'b0, 1'b0);
            if (!ir_early) begin
                bus.infer_ready = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    bus.winner_id = 5'($urandom);
                    tick();
                end
                bus.infer_ready = 1'b1;
            end
            bus.winner_id = win;
            tick();                                      // REPORT
            e_cid = win;
            bus.infer_ready = 1'b0;
            bus.winner_id   = 5'($urandom);
            tick();                                      // IDLE, class_valid
            set_exp(1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            m_step++;
            tick();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_frame(input int abort_step, input bit ir_early, input logic [4:0] win);
        bit ab;
        bus.infer_ready = ir_early;
        for (int s = 0; s < NS; s++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.spike_done = ($urandom_range(0, 1) == 1);
                tick();
            end
            bus.spike_done = 1'b0;
            do_step(fv[s], (s == abort_step) ? 0 : -1, ir_early, win, ab);
            if (ab) break;
        end
        bus.infer_ready = 1'b0;
    endtask

    task automatic rand_vecs();
        for (int s = 0; s < NS; s++) begin
            fv[s] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) fv[s] = '0;
        end
    endtask

    initial begin
        bus.vec_valid   = 1'b0;
        bus.vec_data    = '0;
        bus.spike_done  = 1'b0;
        bus.infer_ready = 1'b0;
        bus.winner_id   = '0;
        reset_model();
        rst_n  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // two sparse events then an otherwise empty frame
        for (int s = 0; s < NS; s++) fv[s] = '0;
        fv[0] = 64'h12;
        do_frame(-1, 1'b0, 5'd7);
        cmp("lit_events_0x12", 64'(bus.frame_events), 64'd2);
        cmp("lit_model_0x12",  64'(e_fev),            64'd2);
        cmp("lit_class_7",     64'(bus.class_id),     64'd7);

        // full vector with infer_ready held high across WIN
        fv[0] = '1;
        do_frame(-1, 1'b1, 5'd19);
        cmp("lit_events_ones", 64'(bus.frame_events), 64'd64);
        cmp("lit_class_19",    64'(bus.class_id),     64'd19);

        // all-empty frame clears the event count at the first acceptance
        fv[0] = '0;
        do_frame(-1, 1'b0, 5'd3);
        cmp("lit_events_zero", 64'(bus.frame_events), 64'd0);
        cmp("lit_class_3",     64'(bus.class_id),     64'd3);

        // reset during WAIT_DONE of step 3, then a fresh frame
        rand_vecs();
        fv[3] = fv[3] | 64'h1;
        do_frame(3, 1'b0, 5'd9);
        cmp("lit_abort_events", 64'(bus.frame_events), 64'd0);
        cmp("lit_abort_class",  64'(bus.class_id),     64'd0);

        for (int f = 0; f < 4; f++) begin
            rand_vecs();
            do_frame(-1, ($urandom_range(0, 1) == 1), 5'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hidden_spike_aer_sequencer.md
# hidden_spike_aer_sequencer

Upstream neighbour of the second-layer no-fire accumulator: takes one hidden-layer spike vector per timestep and serialises its set bits into single AER events (`spike_in` + `spike_AER`). Each event is handshaked against the accumulator's `spike_done`. After `NUM_STEPS` timesteps it requests the winner with `get_winner`, then latches `winner_id` once `infer_ready` rises. It sits between the hidden-layer neuron array and one accumulator instance (one sequencer per ensemble diagonal).

## Interface
- `NUM_HIDDEN`, default 64: hidden neurons per vector; must be ≤ 2^`AER_W`.
- `AER_W`, default 6: AER address width.
- `NUM_STEPS`, default 8: timesteps per inference frame, ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `vec_valid` in 1: spike vector offered.
- `vec_data` in `NUM_HIDDEN`: hidden spikes for one timestep; bit i = neuron i.
- `vec_ready` out 1: sequencer can accept a vector.
- `spike_in` out 1: one-cycle event pulse to the accumulator.
- `spike_AER` out `AER_W`: event address, registered.
- `spike_done` in 1: one-cycle pulse, accumulator finished the current event.
- `get_winner` out 1: one-cycle pulse, request winner evaluation.
- `infer_ready` in 1: accumulator result valid (level).
- `winner_id` in 5: accumulator winner.
- `class_valid` out 1: one-cycle pulse, frame result available.
- `class_id` out 5: latched winner, held until the next `class_valid`.
- `frame_events` out 12: events issued in the current or last frame; saturates at 4095.

## Operation
- States: IDLE, SCAN, ISSUE, WAIT_DONE, STEP_END, WIN, WAIT_INFER, REPORT.
- **IDLE:** `vec_ready`=1. On `vec_valid`&`vec_ready`, register `vec_data` into `pending` and go to SCAN. If `step_cnt`==0, also clear `frame_events` in the same cycle.
- **SCAN:**
  - If `pending`==0, go to STEP_END.
  - Otherwise register the lowest set index into `spike_AER`, clear that bit of `pending`, and go to ISSUE.
- **ISSUE:** `spike_in`=1 for exactly one cycle; `frame_events`+1 (saturating); go to WAIT_DONE.
- **WAIT_DONE:** hold `spike_AER`. On `spike_done`, go to SCAN. There is no timeout.
- **STEP_END:**
  - If `step_cnt`==`NUM_STEPS`-1, clear `step_cnt` and go to WIN.
  - Otherwise `step_cnt`+1 and go to IDLE.
- **WIN:** `get_winner`=1 for one cycle; go to WAIT_INFER.
- **WAIT_INFER:** the first cycle with `infer_ready`=1 latches `winner_id` into `class_id` and goes to REPORT. `infer_ready` in the WIN cycle itself is ignored.
- **REPORT:** `class_valid`=1 for one cycle; go to IDLE.
- Events issue in ascending neuron index order within a vector.
- `spike_done` outside WAIT_DONE is ignored, including a `spike_done` coincident with `spike_in`.
- Bits of `vec_data` at index ≥ `NUM_HIDDEN` do not exist; `pending` is exactly `NUM_HIDDEN` wide.
- `step_cnt` width is clog2(`NUM_STEPS`), minimum 1.

## Timing
- **Reset values:** state=IDLE, `vec_ready`=1, `spike_in`=0, `spike_AER`=0, `get_winner`=0, `class_valid`=0, `class_id`=0, `frame_events`=0, `step_cnt`=0, `pending`=0.
- **Reset mid-frame:** the partial frame is abandoned and no pulse is emitted.
- **Acceptance at cycle t:**
  - SCAN at t+1.
  - First `spike_in` at t+2.
  - An empty vector returns to IDLE with `vec_ready`=1 at t+3.
- **spike_done at cycle d:** next `spike_in` at d+2. An event costs 2 cycles of sequencer overhead plus accumulator latency.
- **Address stability:** `spike_AER` is stable from the `spike_in` cycle through the `spike_done` cycle and changes no earlier than d+1.
- **Frame end:** the last step's STEP_END is followed by `get_winner` in the next cycle. `infer_ready` high at cycle r gives `class_valid` at r+2, with `class_id` valid from that same cycle.
- **vec_ready:** high only in IDLE. A vector offered elsewhere is held by the producer; the valid/ready rule is that data may not change while valid & !ready.

## Structure
- Shared package holds the state enum, `AER_W`, the class-id width (5), and the `frame_events` width (12).
- One sub-module, `lowest_set_bit_enc` (parameter `N`), is natural:
  - combinational priority encoder over `pending`;
  - outputs the index and an `any` flag;
  - its result is registered in SCAN.

## Test plan
- `NUM_STEPS`=1, `vec_data`=0x0000_0000_0000_0012, `spike_done` 3 cycles after each `spike_in` → events at AER 1 then 4, `frame_events`=2, `get_winner` pulse, `infer_ready`+`winner_id`=7 → `class_valid`, `class_id`=7.
- All-ones vector → 64 events, AER 0..63 in order, `frame_events`=64.
- `NUM_STEPS`=8, all-zero vectors → eight acceptances each 3 cycles apart, then `get_winner`, `frame_events`=0.
- Stray `spike_done` in IDLE and coincident with `spike_in` → ignored; sequencer stays in WAIT_DONE until the next `spike_done`.
- `infer_ready` held high continuously from before the frame → ignored through WIN; `class_id` latches `winner_id` in the first WAIT_INFER cycle.
- `rst_n` asserted during WAIT_DONE of step 3 → all outputs at reset values immediately; the next frame restarts at `step_cnt`=0 and `frame_events` counts from 0.
